// File: rtl/uart_fifo_periph_if.sv
// MEM-stage bus bundle for the UART peripheral: strobes, address and data.
// The CPU side drives the master modport; the peripheral uses the slave modport.
interface uart_fifo_periph_if;
   logic        rd;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output rd, output wr, output addr, output wdata, input rdata);
   modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_fifo_periph.sv
// Memory-mapped UART: TX/RX FIFOs, programmable bit period, sticky errors, maskable level IRQ.
// Register block: TXDATA 0x0, RXDATA 0x4, STATUS 0x8, CTRL 0xC relative to BASE_ADDR.
module uart_fifo_periph #(
   parameter int          CLKS_PER_BIT = 10416,
   parameter int          DATA_W       = 8,
   parameter int          TX_DEPTH     = 16,
   parameter int          RX_DEPTH     = 16,
   parameter logic [31:0] BASE_ADDR    = 32'h4000_0020
) (
   input  logic                clk,
   input  logic                reset,
   uart_fifo_periph_if.slave   bus,
   input  logic                UART_RX,
   output logic                UART_TX,
   output logic                irqout
);

   localparam int TAW = $clog2(TX_DEPTH);
   localparam int TCW = TAW + 1;
   localparam int RAW = $clog2(RX_DEPTH);
   localparam int RCW = RAW + 1;
   localparam int CW  = $clog2(CLKS_PER_BIT);
   localparam int BW  = $clog2(DATA_W);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

   // Bus decode
   logic       sel;
   logic [1:0] reg_sel;
   logic       wr_tx, rd_rx, wr_stat, wr_ctrl;

   assign sel     = (bus.addr[31:4] == BASE_ADDR[31:4]);
   assign reg_sel = bus.addr[3:2];
   assign wr_tx   = sel & bus.wr & (reg_sel == 2'd0);
   assign rd_rx   = sel & bus.rd & (reg_sel == 2'd1);
   assign wr_stat = sel & bus.wr & (reg_sel == 2'd2);
   assign wr_ctrl = sel & bus.wr & (reg_sel == 2'd3);

   logic unused_bus;
   assign unused_bus = ^{bus.addr[1:0], bus.wdata[31:6]};

   // TX FIFO
   logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
   logic [TAW-1:0]    tx_wp_q, tx_rp_q;
   logic [TCW-1:0]    tx_cnt_q;
   logic              tx_empty, tx_full, tx_push, tx_pop, tx_ovf_set;

   assign tx_empty   = (tx_cnt_q == '0);
   assign tx_full    = (tx_cnt_q == TCW'(TX_DEPTH));
   assign tx_push    = wr_tx & (~tx_full | tx_pop);
   assign tx_ovf_set = wr_tx & tx_full & ~tx_pop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         tx_cnt_q <= '0;
      end else begin
         if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
         if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
         tx_cnt_q <= tx_cnt_q + TCW'(tx_push) - TCW'(tx_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem_q[tx_wp_q] <= bus.wdata[DATA_W-1:0];
   end

   // RX FIFO; a pop on an empty FIFO is suppressed, so push+pop when empty keeps the push
   logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
   logic [RAW-1:0]    rx_wp_q, rx_rp_q;
   logic [RCW-1:0]    rx_cnt_q;
   logic              rx_empty, rx_full, rx_push_req, rx_push, rx_pop, rx_ovf_set;
   logic [DATA_W-1:0] rx_sh_q;

   assign rx_empty   = (rx_cnt_q == '0);
   assign rx_full    = (rx_cnt_q == RCW'(RX_DEPTH));
   assign rx_pop     = rd_rx & ~rx_empty;
   assign rx_push    = rx_push_req & (~rx_full | rx_pop);
   assign rx_ovf_set = rx_push_req & rx_full & ~rx_pop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         rx_cnt_q <= '0;
      end else begin
         if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
         if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
         rx_cnt_q <= rx_cnt_q + RCW'(rx_push) - RCW'(rx_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem_q[rx_wp_q] <= rx_sh_q;
   end

   // TX FSM
   uart_state_e       tx_st_q;
   logic [CW-1:0]     tx_tmr_q;
   logic [BW-1:0]     tx_bit_q;
   logic [DATA_W-1:0] tx_sh_q;
   logic              tx_q, tx_done, tx_busy;

   assign tx_done = (tx_tmr_q == BIT_END);
   assign tx_pop  = ~tx_empty & ((tx_st_q == S_IDLE) | ((tx_st_q == S_STOP) & tx_done));
   assign tx_busy = ~tx_empty | (tx_st_q != S_IDLE);
   assign UART_TX = tx_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_st_q  <= S_IDLE;
         tx_tmr_q <= '0;
         tx_bit_q <= '0;
         tx_sh_q  <= '0;
         tx_q     <= 1'b1;
      end else begin
         case (tx_st_q)
            S_IDLE: if (tx_pop) begin
               tx_sh_q  <= tx_mem_q[tx_rp_q];
               tx_q     <= 1'b0;
               tx_tmr_q <= '0;
               tx_st_q  <= S_START;
            end
            S_START: if (tx_done) begin
               tx_tmr_q <= '0;
               tx_bit_q <= '0;
               tx_q     <= tx_sh_q[0];
               tx_st_q  <= S_DATA;
            end else tx_tmr_q <= tx_tmr_q + 1'b1;
            S_DATA: if (tx_done) begin
               tx_tmr_q <= '0;
               if (tx_bit_q == LAST_BIT) begin
                  tx_q    <= 1'b1;
                  tx_st_q <= S_STOP;
               end else begin
                  tx_bit_q <= tx_bit_q + 1'b1;
                  tx_sh_q  <= tx_sh_q >> 1;
                  tx_q     <= tx_sh_q[1];
               end
            end else tx_tmr_q <= tx_tmr_q + 1'b1;
            S_STOP: if (tx_done) begin
               // chain straight into the next start bit when more data is queued
               if (tx_pop) begin
                  tx_sh_q  <= tx_mem_q[tx_rp_q];
                  tx_q     <= 1'b0;
                  tx_tmr_q <= '0;
                  tx_st_q  <= S_START;
               end else tx_st_q <= S_IDLE;
            end else tx_tmr_q <= tx_tmr_q + 1'b1;
            default: tx_st_q <= S_IDLE;
         endcase
      end
   end

   // RX synchroniser and FSM
   uart_state_e   rx_st_q;
   logic [CW-1:0] rx_tmr_q;
   logic [BW-1:0] rx_bit_q;
   logic          rx_meta_q, rx_s_q, rx_prev_q, rx_done, frm_set;

   assign rx_done     = (rx_tmr_q == BIT_END);
   assign rx_push_req = (rx_st_q == S_STOP) & rx_done & rx_s_q;
   assign frm_set     = (rx_st_q == S_STOP) & rx_done & ~rx_s_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
         rx_st_q   <= S_IDLE;
         rx_tmr_q  <= '0;
         rx_bit_q  <= '0;
         rx_sh_q   <= '0;
      end else begin
         rx_meta_q <= UART_RX;
         rx_s_q    <= rx_meta_q;
         rx_prev_q <= rx_s_q;
         case (rx_st_q)
            S_IDLE: if (rx_prev_q & ~rx_s_q) begin
               rx_tmr_q <= '0;
               rx_st_q  <= S_START;
            end
            S_START: if (rx_tmr_q == HALF_END) begin
               rx_tmr_q <= '0;
               rx_bit_q <= '0;
               rx_st_q  <= rx_s_q ? S_IDLE : S_DATA;
            end else rx_tmr_q <= rx_tmr_q + 1'b1;
            S_DATA: if (rx_done) begin
               rx_tmr_q <= '0;
               rx_sh_q  <= {rx_s_q, rx_sh_q[DATA_W-1:1]};
               if (rx_bit_q == LAST_BIT) rx_st_q <= S_STOP;
               else rx_bit_q <= rx_bit_q + 1'b1;
            end else rx_tmr_q <= rx_tmr_q + 1'b1;
            S_STOP: if (rx_done) rx_st_q <= S_IDLE;
            else rx_tmr_q <= rx_tmr_q + 1'b1;
            default: rx_st_q <= S_IDLE;
         endcase
      end
   end

   // Sticky flags (set beats clear), control and interrupt
   logic       rx_ovf_q, frm_q, tx_ovf_q, irq_q;
   logic [1:0] ctrl_q;
   logic [2:0] stat_clr;

   assign stat_clr = wr_stat ? bus.wdata[5:3] : '0;
   assign irqout   = irq_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_ovf_q <= 1'b0;
         frm_q    <= 1'b0;
         tx_ovf_q <= 1'b0;
         ctrl_q   <= '0;
         irq_q    <= 1'b0;
      end else begin
         rx_ovf_q <= rx_ovf_set | (rx_ovf_q & ~stat_clr[0]);
         frm_q    <= frm_set    | (frm_q    & ~stat_clr[1]);
         tx_ovf_q <= tx_ovf_set | (tx_ovf_q & ~stat_clr[2]);
         if (wr_ctrl) ctrl_q <= bus.wdata[1:0];
         irq_q <= (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & ~tx_busy);
      end
   end

   always_comb begin
      bus.rdata = '0;
      if (sel && bus.rd) begin
         case (reg_sel)
            2'd1: if (!rx_empty) bus.rdata = 32'(rx_mem_q[rx_rp_q]);
            2'd2: bus.rdata = {8'h00, 8'(tx_cnt_q), 8'(rx_cnt_q), 2'b00,
                               tx_ovf_q, frm_q, rx_ovf_q, tx_busy, tx_full, ~rx_empty};
            2'd3: bus.rdata = {30'd0, ctrl_q};
            default: bus.rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_fifo_periph.sv
// Directed bench for uart_fifo_periph at 4 clocks per bit with 16-entry FIFOs.
// Drives and samples on the falling clock edge; expected values are fixed constants.
module tb_uart_fifo_periph;

   localparam logic [31:0] A_TX = 32'h4000_0020;
   localparam logic [31:0] A_RX = 32'h4000_0024;
   localparam logic [31:0] A_ST = 32'h4000_0028;
   localparam logic [31:0] A_CT = 32'h4000_002C;

   logic clk = 1'b0;
   logic reset;
   logic UART_RX;
   logic UART_TX;
   logic irqout;
   int   n_chk;
   int   n_pass;

   uart_fifo_periph_if bus ();

   uart_fifo_periph #(
      .CLKS_PER_BIT (4),
      .DATA_W       (8),
      .TX_DEPTH     (16),
      .RX_DEPTH     (16),
      .BASE_ADDR    (32'h4000_0020)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus.slave),
      .UART_RX (UART_RX),
      .UART_TX (UART_TX),
      .irqout  (irqout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      else n_pass++;
   endtask

   // Combinational read inside the low clock phase; never spans a rising edge.
   task automatic peek(input logic [31:0] a, output logic [31:0] d);
      bus.rd   = 1'b1;
      bus.addr = a;
      #1;
      d        = bus.rdata;
      bus.rd   = 1'b0;
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.wr    = 1'b1;
      bus.addr  = a;
      bus.wdata = d;
      @(negedge clk);
      bus.wr    = 1'b0;
   endtask

   task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.rd   = 1'b1;
      bus.addr = a;
      #1;
      d        = bus.rdata;
      @(negedge clk);
      bus.rd   = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         UART_RX = bits[i];
         repeat (4) @(negedge clk);
      end
      UART_RX = 1'b1;
   endtask

   // Returns {stop, data[7:0], start}; all ones if no start bit appears in time.
   task automatic tx_capture(output logic [9:0] fr, output int waits);
      waits = 0;
      fr    = '1;
      do begin
         @(negedge clk);
         waits++;
      end while (UART_TX !== 1'b0 && waits < 400);
      if (UART_TX === 1'b0) begin
         repeat (2) @(negedge clk);
         fr[0] = UART_TX;
         for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge clk);
            fr[i+1] = UART_TX;
         end
         repeat (4) @(negedge clk);
         fr[9] = UART_TX;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time %0t reached, limit 1000000", $time);
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      logic [39:0] wave;
      int          busy_n;
      int          max_gap;
      n_chk = 0;
      n_pass = 0;
      reset = 1'b0;
      UART_RX = 1'b1;
      bus.rd = 1'b0;
      bus.wr = 1'b0;
      bus.addr = '0;
      bus.wdata = '0;
      repeat (3) @(negedge clk);
      check("rst UART_TX", UART_TX, 1'b1);
      check("rst irqout", irqout, 1'b0);
      peek(A_ST, d); check("rst STATUS", d, 32'h0);
      peek(A_CT, d); check("rst CTRL", d, 32'h0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // single 0x55 frame, cycle-exact waveform
      bus_wr(A_TX, 32'h55);
      peek(A_ST, d); check("t1 STATUS queued", d, 32'h0001_0004);
      check("t1 line idle", UART_TX, 1'b1);
      busy_n = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         wave[k] = UART_TX;
         peek(A_ST, d);
         if (d == 32'h0000_0004) busy_n++;
      end
      check("t1 waveform", wave, 40'hF0F0F0F0F0);
      check("t1 busy samples", busy_n, 40);
      @(negedge clk);
      peek(A_ST, d); check("t1 STATUS done", d, 32'h0);

      // 18 back-to-back writes: one in shifter, 16 queued, last dropped
      max_gap = 0;
      fork
         begin
            for (int i = 0; i < 18; i++) begin
               @(negedge clk);
               bus.wr = 1'b1;
               bus.addr = A_TX;
               bus.wdata = 32'h10 + i;
            end
            @(negedge clk);
            bus.wr = 1'b0;
            peek(A_ST, d); check("t2 STATUS full", d, 32'h0010_0026);
         end
         begin
            logic [9:0] fr;
            int         gap;
            for (int i = 0; i < 17; i++) begin
               tx_capture(fr, gap);
               check("t2 frame", fr, {1'b1, 8'(8'h10 + i), 1'b0});
               if (i > 0 && gap > max_gap) max_gap = gap;
            end
         end
      join
      check("t2 max gap", max_gap, 2);
      repeat (6) @(negedge clk);
      peek(A_ST, d); check("t2 STATUS after", d, 32'h0000_0020);
      bus_wr(A_ST, 32'h38);
      peek(A_ST, d); check("t2 TX_OVF clear", d, 32'h0);

      bus_wr(32'h4000_0030, 32'h77);
      bus_wr(A_RX, 32'h66);
      repeat (2) @(negedge clk);
      peek(A_ST, d); check("unmapped writes", d, 32'h0);

      // RX 0xA3 with rx irq enabled
      bus_wr(A_CT, 32'h1);
      send_rx(8'hA3, 1'b1);
      repeat (4) @(negedge clk);
      peek(A_ST, d); check("t3 STATUS", d, 32'h0000_0101);
      check("t3 irq set", irqout, 1'b1);
      bus.addr = A_ST;
      #1;
      check("t3 rdata rd=0", bus.rdata, 32'h0);
      peek(32'h4000_0128, d); check("t3 other block", d, 32'h0);
      bus_rd(A_RX, d); check("t3 RXDATA", d, 32'h0000_00A3);
      peek(A_ST, d); check("t3 STATUS popped", d, 32'h0);
      @(negedge clk);
      check("t3 irq clear", irqout, 1'b0);
      bus_wr(A_CT, 32'hFFFF_FFFF);
      peek(A_CT, d); check("CTRL readback", d, 32'h3);
      @(negedge clk);
      check("txe irq", irqout, 1'b1);
      bus_wr(A_CT, 32'h0);
      @(negedge clk);
      check("irq masked", irqout, 1'b0);

      // framing error
      send_rx(8'h5A, 1'b0);
      repeat (4) @(negedge clk);
      peek(A_ST, d); check("t4 FRM_ERR", d, 32'h0000_0010);
      bus_wr(A_ST, 32'h10);
      peek(A_ST, d); check("t4 FRM clear", d, 32'h0);

      // glitch, then RX overflow
      @(negedge clk); UART_RX = 1'b0;
      @(negedge clk); UART_RX = 1'b1;
      repeat (20) @(negedge clk);
      peek(A_ST, d); check("t5 glitch", d, 32'h0);
      for (int i = 0; i < 17; i++) send_rx(8'(i * 13 + 5), 1'b1);
      repeat (4) @(negedge clk);
      peek(A_ST, d); check("t5 STATUS ovf", d, 32'h0000_1009);
      for (int i = 0; i < 16; i++) begin
         bus_rd(A_RX, d);
         check("t5 RXDATA", d, {24'h0, 8'(i * 13 + 5)});
      end
      bus_rd(A_RX, d); check("t5 empty read", d, 32'h0);
      peek(A_ST, d); check("t5 STATUS drained", d, 32'h0000_0008);
      bus_wr(A_ST, 32'h08);
      peek(A_ST, d); check("t5 RX_OVF clear", d, 32'h0);

      // reset mid TX and mid RX frame
      bus_wr(A_TX, 32'h00);
      @(negedge clk); UART_RX = 1'b0;
      repeat (12) @(negedge clk);
      check("t6 TX mid frame", UART_TX, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check("t6 async TX", UART_TX, 1'b1);
      peek(A_ST, d); check("t6 STATUS in reset", d, 32'h0);
      UART_RX = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (30) @(negedge clk);
      peek(A_ST, d); check("t6 STATUS after", d, 32'h0);
      fork
         bus_wr(A_TX, 32'hC3);
         begin
            logic [9:0] fr;
            int         gap;
            tx_capture(fr, gap);
            check("t6 TX frame", fr, {1'b1, 8'hC3, 1'b0});
         end
      join
      send_rx(8'h3C, 1'b1);
      repeat (4) @(negedge clk);
      bus_rd(A_RX, d); check("t6 RXDATA", d, 32'h0000_003C);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
